// File: rtl/seq_scan_ctrl.sv
// Serial pattern scanner: accepts bytes, shifts them MSB-first into a history
// register and counts pattern matches. Define SEQ_SCAN_OVERLAP_EN to count overlapping matches.
module seq_scan_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       cfg_pattern,
  input  logic [3:0]       cfg_len,
  input  logic [CNT_W-1:0] cfg_thresh,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             busy,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_count,
  output logic             done,
  output logic             irq,
  input  logic             irq_clr
);

`ifdef SEQ_SCAN_OVERLAP_EN
  localparam bit Overlap = 1'b1;
`else
  localparam bit Overlap = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e           state_q;
  logic [7:0]       pat_q;
  logic [3:0]       len_q;
  logic [CNT_W-1:0] thr_q;
  logic [7:0]       data_q;
  logic             last_q;
  logic [7:0]       hist_q;
  logic [3:0]       seen_q;
  logic [2:0]       bit_cnt_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ready_q;
  logic             busy_q;
  logic             pulse_q;
  logic             done_q;
  logic             irq_q;

  logic [7:0]       hist_d;
  logic [3:0]       seen_d;
  logic [7:0]       len_mask;
  logic [3:0]       len_clamp;
  logic [CNT_W-1:0] cnt_inc;
  logic             hit;

  // NOTE: every signal assigned here gets a value on every path, so no latches are inferred.
  always_comb begin
    hist_d   = {hist_q[6:0], data_q[7]};
    seen_d   = (seen_q >= 4'd8) ? seen_q : seen_q + 4'd1;
    len_mask = 8'h00;
    for (int i = 0; i < 8; i++) begin
      len_mask[i] = (4'(i) < len_q);
    end
    hit     = (((hist_d ^ pat_q) & len_mask) == 8'h00) && (seen_d >= len_q);
    cnt_inc = cnt_q + CNT_W'(1);
    if (cfg_len == 4'd0)      len_clamp = 4'd1;
    else if (cfg_len > 4'd8)  len_clamp = 4'd8;
    else                      len_clamp = cfg_len;
  end

  // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pat_q     <= 8'h00;
      len_q     <= 4'd1;
      thr_q     <= '0;
      data_q    <= 8'h00;
      last_q    <= 1'b0;
      hist_q    <= 8'h00;
      seen_q    <= 4'd0;
      bit_cnt_q <= 3'd0;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      pulse_q   <= 1'b0;
      done_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
      if (irq_clr) irq_q <= 1'b0;

      if (abort && state_q != S_IDLE) begin
        // A shift in flight is dropped, so its match neither counts nor pulses.
        state_q <= S_IDLE;
        ready_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start) begin
              pat_q     <= cfg_pattern;
              len_q     <= len_clamp;
              thr_q     <= cfg_thresh;
              cnt_q     <= '0;
              hist_q    <= 8'h00;
              seen_q    <= 4'd0;
              bit_cnt_q <= 3'd0;
              state_q   <= S_WAIT;
              ready_q   <= 1'b1;
              busy_q    <= 1'b1;
            end
          end
          S_WAIT: begin
            if (in_valid) begin
              data_q    <= in_data;
              last_q    <= in_last;
              bit_cnt_q <= 3'd0;
              state_q   <= S_SHIFT;
              ready_q   <= 1'b0;
            end
          end
          S_SHIFT: begin
            hist_q    <= hist_d;
            data_q    <= {data_q[6:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            seen_q    <= (hit && !Overlap) ? 4'd0 : seen_d;
            if (hit) begin
              pulse_q <= 1'b1;
              if (!(&cnt_q)) begin
                cnt_q <= cnt_inc;
                // Set is evaluated after clear above, so a coincident set wins.
                if (thr_q != '0 && cnt_inc == thr_q) irq_q <= 1'b1;
              end
            end
            if (bit_cnt_q == 3'd7) begin
              if (last_q) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_WAIT;
                ready_q <= 1'b1;
              end
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign in_ready    = ready_q;
  assign busy        = busy_q;
  assign match_pulse = pulse_q;
  assign match_count = cnt_q;
  assign done        = done_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl: directed scenarios plus random jobs
// compared against a bit-stream window model.
module tb_seq_scan_ctrl;
  localparam int CNT_W = 16;

`ifdef SEQ_SCAN_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [7:0]       cfg_pattern = 8'h00;
  logic [3:0]       cfg_len = 4'd1;
  logic [CNT_W-1:0] cfg_thresh = '0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             in_last = 1'b0;
  logic             in_ready;
  logic             busy;
  logic             match_pulse;
  logic [CNT_W-1:0] match_count;
  logic             done;
  logic             irq;
  logic             irq_clr = 1'b0;

  seq_scan_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_thresh(cfg_thresh),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .busy(busy), .match_pulse(match_pulse),
    .match_count(match_count), .done(done), .irq(irq), .irq_clr(irq_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Event monitor, sampled on the falling edge.
  int   pulse_cnt = 0;
  int   done_cnt  = 0;
  int   irq_rise_pulse = 0;
  logic irq_prev = 1'b0;
  always @(negedge clk) begin
    if (match_pulse) pulse_cnt++;
    if (done) done_cnt++;
    if (irq && !irq_prev) irq_rise_pulse = pulse_cnt;
    irq_prev = irq;
  end

  logic [7:0] job_bytes [0:3];
  int         last_delay;
  int         last_irq_rise;

  // Reference: slide a len-wide window over the bit stream; without overlap a
  // window may not reuse bits consumed by the previous match.
  function automatic int model_count(input logic [7:0] pat, input int len_raw, input int nbytes);
    int len;
    int cnt;
    int first;
    bit bits [$];
    bit eq;
    len = (len_raw == 0) ? 1 : (len_raw > 8 ? 8 : len_raw);
    for (int b = 0; b < nbytes; b++)
      for (int i = 7; i >= 0; i--) bits.push_back(job_bytes[b][i]);
    cnt = 0;
    first = 0;
    for (int i = 0; i < bits.size(); i++) begin
      if (i - first + 1 >= len) begin
        eq = 1'b1;
        for (int k = 0; k < len; k++)
          if (bits[i - len + 1 + k] != pat[len - 1 - k]) eq = 1'b0;
        if (eq) begin
          cnt++;
          if (!OVL) first = i + 1;
        end
      end
    end
    return cnt;
  endfunction

  task automatic wait_ready(output bit ok);
    int w = 0;
    while (!in_ready && w < 30) begin
      @(negedge clk);
      w++;
    end
    ok = in_ready;
  endtask

  task automatic run_job(input logic [7:0] pat, input logic [3:0] len, input logic [CNT_W-1:0] thr,
                         input int nbytes, input bit gaps, input string tag);
    int  p0, d0, exp_cnt, w;
    time t_acc, t_done;
    bit  ok;
    @(negedge clk); #1;
    p0 = pulse_cnt;
    d0 = done_cnt;
    t_acc = $time;
    start = 1'b1; irq_clr = 1'b1;
    cfg_pattern = pat; cfg_len = len; cfg_thresh = thr;
    @(negedge clk);
    start = 1'b0; irq_clr = 1'b0;
    for (int b = 0; b < nbytes; b++) begin
      wait_ready(ok);
      if (!ok) begin
        check({tag, "_ready_timeout"}, 0, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        return;
      end
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      in_valid = 1'b1;
      in_data  = job_bytes[b];
      in_last  = (b == nbytes - 1);
      if (b == 0) t_acc = $time;
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
    w = 0;
    while (!done && w < 30) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_done_seen"}, done, 1);
    t_done = $time;
    last_delay = int'((t_done - t_acc) / 10);
    repeat (2) @(negedge clk);
    #1;
    exp_cnt = model_count(pat, int'(len), nbytes);
    check({tag, "_count"}, match_count, exp_cnt);
    check({tag, "_pulses"}, pulse_cnt - p0, exp_cnt);
    check({tag, "_done_once"}, done_cnt - d0, 1);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_irq"}, irq, (thr != 0 && exp_cnt >= int'(thr)));
    last_irq_rise = irq_rise_pulse - p0;
  endtask

  initial begin
    int  p0, d0;
    bit  ok;
    int  nb;
    logic [3:0] rlen;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 0);
    check("rst_pulse", match_pulse, 0);
    check("rst_done", done, 0);
    check("rst_irq", irq, 0);
    check("rst_count", match_count, 0);
    rst_n = 1'b1;
    @(negedge clk);

    job_bytes[0] = 8'h36;
    run_job(8'h03, 4'd3, '0, 1, 1'b0, "p03_x36");
    check("p03_x36_spec", match_count, 2);

    job_bytes[0] = 8'hAA;
    run_job(8'h05, 4'd3, '0, 1, 1'b0, "p05_xAA");
    check("p05_xAA_spec", match_count, OVL ? 3 : 2);

    job_bytes[0] = 8'h03; job_bytes[1] = 8'hC0;
    run_job(8'h0F, 4'd4, '0, 2, 1'b0, "cross");
    check("cross_spec", match_count, 1);
    check("cross_latency_ge18", (last_delay >= 18), 1);

    job_bytes[0] = 8'h07;
    run_job(8'h01, 4'd1, 16'd2, 1, 1'b0, "irq");
    check("irq_rise_at_2nd", last_irq_rise, 2);
    repeat (3) @(negedge clk);
    check("irq_sticky", irq, 1);
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    check("irq_cleared", irq, 0);

    // Abort in the 4th shift cycle
    @(negedge clk); #1;
    p0 = pulse_cnt; d0 = done_cnt;
    start = 1'b1; cfg_pattern = 8'h01; cfg_len = 4'd1; cfg_thresh = '0;
    @(negedge clk);
    start = 1'b0;
    wait_ready(ok);
    check("abort_ready", ok, 1);
    in_valid = 1'b1; in_data = 8'hF0; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_ready_low", in_ready, 0);
    check("abort_count", match_count, 3);
    repeat (12) @(negedge clk);
    #1;
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_pulses", pulse_cnt - p0, 3);
    check("abort_held", match_count, 3);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_cleared", match_count, 0);
    check("restart_busy", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;

    // Reset in the middle of a shift
    @(negedge clk); #1;
    d0 = done_cnt;
    start = 1'b1; cfg_pattern = 8'h01; cfg_len = 4'd1; cfg_thresh = 16'd1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_irq", irq, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_count", match_count, 0);
    check("mid_rst_irq", irq, 0);
    check("mid_rst_pulse", match_pulse, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    check("rst_no_done", done_cnt - d0, 0);

    job_bytes[0] = 8'h81;
    run_job(8'h01, 4'd0, '0, 1, 1'b0, "len0");
    check("len0_spec", match_count, 2);

    // Random jobs
    for (int j = 0; j < 30; j++) begin
      nb = $urandom_range(1, 4);
      for (int b = 0; b < 4; b++) job_bytes[b] = 8'($urandom);
      rlen = 4'($urandom_range(0, 11));
      run_job(8'($urandom), rlen, CNT_W'($urandom_range(0, 5)), nb, 1'b1, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
